// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states, add/sub op encodings, slice width.
package alu_pkg;

  localparam int SLICE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fa4bit.sv
// 4-bit ripple adder slice; purely combinational.
module fa4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/serial_add_seq.sv
// Multi-precision add/subtract sequencer: one 4-bit slice per clock through a
// single shared fa4bit, LS nibble first, with the carry chained in a register.
module serial_add_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         op,
  input  logic [SLICE_W*NIBBLES-1:0]   a,
  input  logic [SLICE_W*NIBBLES-1:0]   b,
  input  logic                         cin_in,
  output logic                         busy,
  output logic                         done,
  output logic [SLICE_W*NIBBLES-1:0]   result,
  output logic                         cout,
  output logic                         ovf
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  seq_state_t     state, state_nxt;
  logic [W-1:0]   a_sh, b_sh, res_sh;
  logic [W-1:0]   b_eff, res_shifted;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           a_sign, b_sign;
  logic [3:0]     fa_sum;
  logic           fa_cout;
  logic           accept, last_slice;

  // Subtract is a + ~b + 1: invert B here, force carry-in to 1 at accept.
  assign b_eff       = (op == OP_SUB) ? ~b : b;
  assign accept      = (state == IDLE) && start;
  assign last_slice  = (state == RUN) && (cnt == CW'(NIBBLES - 1));
  // Written as shifts so the expression stays legal when W == SLICE_W.
  assign res_shifted = (res_sh >> SLICE_W) | (W'(fa_sum) << (W - SLICE_W));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  fa4bit u_fa (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after NIBBLES slices, DONE -> IDLE.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, carry, counter and the registered outputs.
  // NOTE: every register here is plain flops, so all of them are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_eff;
      res_sh <= '0;
      carry  <= (op == OP_SUB) ? 1'b1 : cin_in;
      cnt    <= '0;
      a_sign <= a[W-1];
      b_sign <= b_eff[W-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> SLICE_W;
      b_sh   <= b_sh >> SLICE_W;
      res_sh <= res_shifted;
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last_slice) begin
        result <= res_shifted;
        cout   <= fa_cout;
        ovf    <= (a_sign == b_sign) && (res_shifted[W-1] != a_sign);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (NIBBLES = 4) with a result scoreboard.
module tb_serial_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a, b;
  logic        cin_in;
  logic        busy, done, cout, ovf;
  logic [15:0] result;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  serial_add_seq #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin_in (cin_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: full-width two's-complement add of a and (possibly inverted) b.
  function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                 input logic ci);
    logic [15:0] ye;
    logic [16:0] s;
    exp_t e;
    ye   = o ? ~y : y;
    s    = {1'b0, x} + {1'b0, ye} + 17'(o ? 1'b1 : ci);
    e.res = s[15:0];
    e.co  = s[16];
    e.ov  = (x[15] == ye[15]) && (s[15] != x[15]);
    return e;
  endfunction

  // Present an operation (call just after a negedge); optionally record its expectation.
  task automatic drive_start(input logic o, input logic [15:0] x, input logic [15:0] y,
                             input logic ci, input bit push);
    op = o; a = x; b = y; cin_in = ci; start = 1'b1;
    if (push) sb.push_back(model(o, x, y, ci));
  endtask

  // Compare the DUT output against the oldest scoreboard entry.
  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: done with no outstanding operation (result=%h)", name, result);
      return;
    end
    e = sb.pop_front();
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, e.res);
    end
    checks++;
    if (cout !== e.co) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, cout, e.co);
    end
    checks++;
    if (ovf !== e.ov) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, e.ov);
    end
  endtask

  // Watch a fixed number of cycles at negedges, checking every done pulse.
  task automatic watch(input string name, input int ncyc, output int ndone);
    ndone = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        check_result(name);
      end
    end
  endtask

  // Full single operation with latency, busy-width, stability and pulse-width checks.
  task automatic run_op(input string name, input logic o, input logic [15:0] x,
                        input logic [15:0] y, input logic ci, input bit check_timing);
    int lat, busy_cnt;
    bit got, stable;
    logic [15:0] prev;
    @(negedge clk);
    drive_start(o, x, y, ci, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; lat = 0; busy_cnt = 0; stable = 1; prev = result;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = c; got = 1;
        break;
      end
      if (result !== prev) stable = 0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
      return;
    end
    check_result(name);
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s stable: result changed during RUN (got %h, was %h)", name, result, prev);
    end
    if (check_timing) begin
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL %s latency: got %0d expected 5", name, lat);
      end
      checks++;
      if (busy_cnt != 5) begin
        errors++;
        $display("FAIL %s busy cycles: got %0d expected 5", name, busy_cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, result, cout, ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, ovf);
    end
    #10 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle after reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    run_op("add_1234_4321", alu_pkg::OP_ADD, 16'h1234, 16'h4321, 1'b0, 1'b1);
    run_op("add_ffff_0001", alu_pkg::OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    run_op("add_7fff_cin",  alu_pkg::OP_ADD, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_5_7",       alu_pkg::OP_SUB, 16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op("sub_8000_0001", alu_pkg::OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0);
  endtask

  // Start pulse and operand changes during RUN must not disturb the running op.
  task automatic test_ignore_start();
    int nd;
    @(negedge clk);
    drive_start(alu_pkg::OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_start(alu_pkg::OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin_in = 1'b1;
    watch("ignore_start", 10, nd);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL ignore_start done count: got %0d expected 1", nd);
    end
  endtask

  // start held high: accepts on every first IDLE cycle, 6 cycles apart.
  task automatic test_back_to_back();
    int t[3];
    int nd = 0;
    int extra;
    @(negedge clk);
    drive_start(alu_pkg::OP_ADD, 16'h0F0F, 16'h0101, 1'b1, 1'b1);
    sb.push_back(model(alu_pkg::OP_ADD, 16'h0F0F, 16'h0101, 1'b1));
    sb.push_back(model(alu_pkg::OP_ADD, 16'h0F0F, 16'h0101, 1'b1));
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t[nd] = cyc;
        nd++;
        check_result("back_to_back");
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (nd != 3) begin
      errors++;
      $display("FAIL back_to_back count: got %0d dones expected 3", nd);
      sb.delete();
      return;
    end
    checks++;
    if (t[1] - t[0] != 6 || t[2] - t[1] != 6) begin
      errors++;
      $display("FAIL back_to_back spacing: got %0d,%0d expected 6,6", t[1] - t[0], t[2] - t[1]);
    end
    watch("back_to_back_tail", 8, extra);
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL back_to_back tail: got %0d extra dones expected 0", extra);
    end
  endtask

  // Reset in the 2nd RUN cycle aborts the op, then a fresh op works.
  task automatic test_reset_abort();
    int nd;
    run_op("pre_abort", alu_pkg::OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive_start(alu_pkg::OP_ADD, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cout, ovf} !== 19'd0) begin
      errors++;
      $display("FAIL abort outputs: got busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, ovf);
    end
    watch("abort_in_reset", 2, nd);
    rst_n = 1'b1;
    watch("abort_after", 6, nd);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort done count: got %0d expected 0", nd);
    end
    run_op("add_00ff_0001", alu_pkg::OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; cin_in = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Multi-precision add/subtract sequencer built around the existing 4-bit ripple adder `fa4bit`. It latches two `4*NIBBLES`-bit operands on a start handshake. It then drives one nibble per clock through a single `fa4bit` instance, least-significant nibble first, chaining the carry in a register. It returns the full-width result with carry-out and signed overflow. It sits in the ALU as the wide-arithmetic path that reuses the narrow adder instead of replicating it.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices; operand width `W = 4*NIBBLES`. Legal range is 1..16.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  1  0 = add, 1 = subtract (a − b); latched at start.
- `a`  in  W  operand A; latched at start.
- `b`  in  W  operand B; latched at start.
- `cin_in`  in  1  carry-in for add; ignored for subtract; latched at start.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `result`  out  W  sum or difference; held until the next accepted start.
- `cout`  out  1  final carry. For subtract, 1 = no borrow.
- `ovf`  out  1  two's-complement overflow of the full-width operation.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after `NIBBLES` RUN cycles.
  - DONE → IDLE unconditionally after 1 cycle.
- Start acceptance, in IDLE with `start`=1:
  - Latch `a` into A_sh.
  - Latch b_eff = (`op` ? ~`b` : `b`) into B_sh.
  - Set the carry register to (`op` ? 1 : `cin_in`).
  - Clear the nibble counter and the result shift register.
  - Record the sign bits a[W-1] and b_eff[W-1].
- Each RUN cycle:
  - `fa4bit` takes a = A_sh[3:0], b = B_sh[3:0] and cin = the carry register.
  - Its sum shifts into the result register from the MSB end; A_sh and B_sh shift right by 4.
  - Its cout loads the carry register, and the counter increments.
- Transfer to DONE:
  - `result` = result register.
  - `cout` = carry register.
  - `ovf` = (a_sign == b_eff_sign) && (result[W-1] != a_sign).
- `start` while `busy`=1 (RUN or DONE) is ignored with no effect. Input changes after acceptance do not affect the operation in progress.
- `result`, `cout` and `ovf` change only on entry to DONE. Their previous values are stable through RUN.
- The counter is sized $clog2(NIBBLES+1). There is no wrap within an operation; it clears at each accepted start.

## Timing
- Reset (asynchronous, immediate on `rst_n`=0):
  - state = IDLE.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0.
  - All internal registers cleared.
- Reset asserted mid-operation aborts it: no `done` is produced, and the outputs go to their reset values.
- Latency: with start sampled at edge T, RUN occupies cycles T+1..T+NIBBLES. `done`=1 and the result are valid in cycle T+NIBBLES+1.
- `busy` rises in the cycle after the accepting edge and falls in the cycle after `done`.
- Throughput: one operation per NIBBLES+2 cycles.
  - Earliest next accept is the first IDLE cycle after DONE.
  - A `start` held high continuously re-triggers there.
- `done` is exactly 1 cycle wide and never asserts without a preceding accepted start.
- The `fa4bit` path is purely combinational between registers; its 4-bit ripple is the only critical path.

## Structure
- Shared package `alu_pkg`:
  - state enum `seq_state_t` (IDLE, RUN, DONE);
  - op encodings `OP_ADD`=1'b0, `OP_SUB`=1'b1;
  - constant `SLICE_W`=4.
- Exactly one sub-module: the existing `fa4bit` (ports `a`, `b`, `cin`, `sum`, `cout`), instantiated once and reused every RUN cycle.
- The remaining logic is FSM, counter and shift registers, all in `serial_add_seq`.

## Test plan
All scenarios use NIBBLES=4.
1. add 0x1234 + 0x4321, cin_in=0 → result=0x5555, cout=0, ovf=0; `done` exactly 5 cycles after the accepting edge; `busy` high for 5 cycles.
2. add 0xFFFF + 0x0001, cin_in=0 → result=0x0000, cout=1, ovf=0.
3. add 0x7FFF + 0x0000, cin_in=1 → result=0x8000, cout=0, ovf=1.
4. Subtract cases:
   - sub 0x0005 − 0x0007, with cin_in=0 to confirm it is ignored → 0xFFFE, cout=0, ovf=0.
   - sub 0x8000 − 0x0001 → 0x7FFF, cout=1, ovf=1.
5. Handshake checks:
   - Pulse `start` with 0x1111 + 0x2222 during RUN of 0x0001 + 0x0001 → ignored; result=0x0002 and only one `done`.
   - Changing `a`/`b` mid-RUN does not alter the result.
   - `start` held high → back-to-back operations, each 6 cycles apart.
6. Drop `rst_n` in the 2nd RUN cycle → all outputs 0 immediately and no `done`. After release, 0x00FF + 0x0001 → 0x0100, cout=0.
